complex_incr_seq: RTL
=====================

Name: complex_incr_seq

Overview:
- Sequencer that turns complex-increment requests into a stream of complex values.
- Each request names a component (RE/IM) and a repeat count. Each step emits the current value, then increments the selected component.
- Two request channels (RE, IM) run concurrently with round-robin interleaving into one output stream.
- Sits downstream of the request source; feeds the complex-value logger/checker.

Parameters:
DATA_W, 32, width of each complex component (x, y)
CNT_W, 4, width of request repeat count
SHARED, 1, 1 = single accumulator shared by both channels (persists across requests); 0 = private accumulator per channel, cleared on request acceptance

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
req_valid  in  1  request valid
req_ready  out  1  request ready; high when the channel selected by req_type is idle
req_type  in  1  0 = RE (increment x), 1 = IM (increment y)
req_count  in  CNT_W  number of steps
out_valid  out  1  output beat valid
out_ready  in  1  output beat accepted
out_type  out  1  channel that produced the beat
out_x  out  DATA_W  x value before this step's increment
out_y  out  DATA_W  y value before this step's increment
out_last  out  1  final beat of the request
busy  out  1  any channel active or out_valid high

Behaviour:
- Decided interface: one clock (clk); reset rst is synchronous and active-high.
- Reset values: out_valid=0, out_type=0, out_x=0, out_y=0, out_last=0, busy=0. All accumulators 0, both channels idle, round-robin pointer=RE.
- Per-channel state: active flag, remaining count. SHARED=1 uses one {x,y} accumulator. SHARED=0 uses one accumulator per channel.
- req_ready = !active[req_type]. This is combinational on req_type.
- Request accept: req_valid && req_ready at an edge.
  - count>0: channel goes active, remaining=req_count.
  - count=0: accepted, no beats, channel stays idle.
  - SHARED=0: that channel's accumulator is cleared to 0 on accept, including when count=0.
- Output register loads when it is empty or being drained (out_valid && out_ready) and at least one channel is active.
  - Arbitration: if one channel is active it wins. If both are active, the pointer's channel wins; after each grant the pointer moves to the other channel.
  - At the load edge:
    - payload = granted channel's accumulator value (pre-increment);
    - accumulator x+=1 (RE) or y+=1 (IM), modulo 2^DATA_W;
    - remaining-=1;
    - out_last = (remaining==1);
    - if out_last, channel goes idle at this edge.
- Latency: request accepted in cycle t gives the first beat valid in cycle t+2. Sustained throughput is 1 beat/cycle with out_ready=1.
- Backpressure: while out_valid && !out_ready, the payload is held stable and no accumulator or count changes.
- Same-edge events:
  - A channel freed by its last load shows req_ready=1 in the following cycle, not the same cycle.
  - A request accepted on one channel in the same edge as a load for the other channel is allowed.
- Reset mid-operation: pending beats and remaining counts are dropped and all state returns to reset values at the next edge.
- Accumulator persistence: SHARED=1 keeps its value across requests; only rst clears it.

Test Plan:
1. SHARED=1, out_ready=1. RE count 5 accepted cycle 0, IM count 5 accepted cycle 1 -> 10 beats with (type,x,y):
   - RE(0,0), IM(1,0), RE(1,1), IM(2,1), RE(2,2), IM(3,2), RE(3,3), IM(4,3)
   - RE(4,4) last, IM(5,4) last
   - accumulator ends (5,5); busy falls after the final handshake.
2. SHARED=0, same stimulus -> RE beats (0,0),(1,0),(2,0),(3,0),(4,0); IM beats (0,0),(0,1),(0,2),(0,3),(0,4). Interleaving is as in scenario 1 and the last flag is on the 5th beat of each channel.
3. Backpressure: RE count 3; out_ready low for 3 cycles while the first beat is valid -> out_x=0, out_y=0 stable for those 3 cycles. After release the beats are (0,0),(1,0),(2,0) with no skips or duplicates.
4. Count 0 and occupancy:
   - RE count 0 -> req_ready stays 1, no output beat.
   - RE count 2 accepted -> req_ready for RE=0 until the cycle after its last beat loads; a second RE request is stalled until then.
5. Persistence (SHARED=1): after scenario 1, RE count 2 -> beats (5,5),(6,5). Assert rst mid-stream with 1 beat pending -> the next cycle has out_valid=0 and busy=0; a new RE count 1 -> beat (0,0).
6. Wrap: DATA_W=4, SHARED=1, RE count 15 then RE count 3 -> the second request's beats are (15,0),(0,0),(1,0).

Source files
------------

// File: rtl/complex_incr_seq.sv
// Complex-increment sequencer: two request channels (RE/IM) interleaved
// round-robin into one registered stream of {x,y} values.
module complex_incr_seq #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 4,
  parameter int SHARED = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_type,
  input  logic [CNT_W-1:0]  req_count,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_type,
  output logic [DATA_W-1:0] out_x,
  output logic [DATA_W-1:0] out_y,
  output logic              out_last,
  output logic              busy
);

  localparam bit SH = (SHARED != 0);

  logic [1:0]        active;
  logic [CNT_W-1:0]  remaining [2];
  logic [DATA_W-1:0] acc_x [2];
  logic [DATA_W-1:0] acc_y [2];
  logic              ptr;

  logic take;
  logic load;
  logic grant;
  logic g_acc;
  logic is_last;

  assign req_ready = !active[req_type];
  assign take      = req_valid && req_ready;
  assign load      = (!out_valid || out_ready) && (|active);
  assign busy      = (|active) || out_valid;

  // Shared mode keeps a single accumulator in slot 0.
  assign g_acc   = SH ? 1'b0 : grant;
  assign is_last = (remaining[grant] == CNT_W'(1));

  always_comb begin
    grant = 1'b0;
    unique case (1'b1)
      (active == 2'b11): grant = ptr;
      (active == 2'b10): grant = 1'b1;
      default:           grant = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      active       <= 2'b00;
      remaining[0] <= '0;
      remaining[1] <= '0;
      acc_x[0]     <= '0;
      acc_x[1]     <= '0;
      acc_y[0]     <= '0;
      acc_y[1]     <= '0;
      ptr          <= 1'b0;
      out_valid    <= 1'b0;
      out_type     <= 1'b0;
      out_x        <= '0;
      out_y        <= '0;
      out_last     <= 1'b0;
    end else begin
      if (load) begin
        out_valid <= 1'b1;
        out_type  <= grant;
        out_x     <= acc_x[g_acc];
        out_y     <= acc_y[g_acc];
        out_last  <= is_last;
        if (grant) begin
          acc_y[g_acc] <= acc_y[g_acc] + DATA_W'(1);
        end else begin
          acc_x[g_acc] <= acc_x[g_acc] + DATA_W'(1);
        end
        remaining[grant] <= remaining[grant] - CNT_W'(1);
        if (is_last) begin
          active[grant] <= 1'b0;
        end
        ptr <= !grant;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
      // An accepted channel is idle, so it never collides with the grant.
      if (take) begin
        if (req_count != '0) begin
          active[req_type]    <= 1'b1;
          remaining[req_type] <= req_count;
        end
        if (!SH) begin
          acc_x[req_type] <= '0;
          acc_y[req_type] <= '0;
        end
      end
    end
  end

endmodule
